// File: rtl/gatebach_prime_extract.sv
// GateBach sieve back end: buffers bitmap words in a FIFO, then
// walks set bits and streams each surviving integer as a 64-bit prime.
module gatebach_prime_extract #(
    parameter int NUM_WORDS  = 1000,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic [63:0] start_addr,
    input  logic        cs_in,
    input  logic [9:0]  add_in,
    input  logic [31:0] data_in,
    output logic        prime_valid,
    input  logic        prime_ready,
    output logic [63:0] prime_data,
    output logic [31:0] prime_count,
    output logic        extract_done,
    output logic        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_n;

    logic [41:0]   mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [41:0]   rd_word;

    logic [31:0]   cur_word;
    logic [9:0]    cur_addr;
    logic [63:0]   pending_base, active_base;
    logic [31:0]   run_count;
    logic [4:0]    bit_k;
    logic [63:0]   cand;
    logic          emit, clear, done;

    // Extra pointer bit distinguishes full from empty.
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = cs_in && !full;
    assign rd_word = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= {add_in, data_in};
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow     <= 1'b0;
            pending_base <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (cs_in && full) overflow <= 1'b1;
            if (cs_in && add_in == 10'd0) pending_base <= start_addr;
        end
    end

    always_comb begin
        bit_k = '0;
        for (int i = 31; i >= 0; i--) begin
            if (cur_word[i]) bit_k = 5'(i);
        end
    end

    assign cand = active_base + 64'({cur_addr, 5'b0}) + 64'(bit_k);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        emit    = 1'b0;
        clear   = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (cur_word != 32'd0) begin
                    // 0 and 1 are dropped silently.
                    if (cand < 64'd2) begin
                        clear = 1'b1;
                    end else begin
                        emit  = 1'b1;
                        clear = prime_ready;
                    end
                end else if (cur_addr == 10'(NUM_WORDS - 1)) begin
                    state_n = DONE;
                end else begin
                    state_n = IDLE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            cur_word    <= '0;
            cur_addr    <= '0;
            active_base <= '0;
            run_count   <= '0;
            prime_count <= '0;
        end else begin
            state <= state_n;
            if (pop) begin
                cur_word <= rd_word[31:0];
                cur_addr <= rd_word[41:32];
                if (rd_word[41:32] == 10'd0) active_base <= pending_base;
            end else if (clear) begin
                cur_word <= cur_word & (cur_word - 32'd1);
            end
            if (emit && prime_ready) run_count <= run_count + 32'd1;
            if (done) begin
                prime_count <= run_count;
                run_count   <= '0;
            end
        end
    end

    assign prime_valid  = emit;
    assign prime_data   = emit ? cand : 64'd0;
    assign extract_done = done;

endmodule
